// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: stage state encoding, per-stage bus widths and control-field
// offsets shared by the CPU pipeline stage registers.
package cpu_pipe_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} stage_state_e;

    localparam int IF_ID_CTRL_W  = 1;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 9;
    localparam int ID_EX_DATA_W  = 128;
    localparam int EX_MEM_CTRL_W = 9;
    localparam int EX_MEM_DATA_W = 96;
    localparam int MEM_WB_CTRL_W = 4;
    localparam int MEM_WB_DATA_W = 64;

    // control bus layout: {src[3:0], width[2:0], mem_write, reg_write}
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_WRITE = 1;
    localparam int CTRL_WIDTH_LSB = 2;
    localparam int CTRL_WIDTH_W   = 3;
    localparam int CTRL_SRC_LSB   = 5;
    localparam int CTRL_SRC_W     = 4;
endpackage

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry: one {valid, data, ctrl} holding register; clear beats load.
module pipe_skid_entry #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            ctrl  <= load_ctrl;
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush, bubble
// control zeroing and an optional two-entry skid buffer.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = EX_MEM_DATA_W,
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [1:0]        count_o
);
    logic              main_v, skid_v, accept, emit, main_load, main_clear;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    stage_state_e      state;

    assign accept = in_valid_i & in_ready_o;
    assign emit   = main_v & out_ready_i;

    generate
        if (SKID) begin : g_skid
            // skid only fills when main is full and not draining; it refills main on emit
            assign in_ready_o = !skid_v;
            assign main_load  = skid_v ? emit : accept & (!main_v | emit);
            assign main_clear = flush_i | (emit & !accept & !skid_v);
            pipe_skid_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (main_v & !skid_v & accept & !emit),
                .clear    (flush_i | (skid_v & emit)),
                .load_data(data_i),
                .load_ctrl(ctrl_i),
                .valid    (skid_v),
                .data     (skid_data),
                .ctrl     (skid_ctrl)
            );
        end else begin : g_single
            assign in_ready_o = !main_v | out_ready_i;
            assign main_load  = accept;
            assign main_clear = flush_i | (emit & !accept);
            assign skid_v     = 1'b0;
            assign skid_data  = '0;
            assign skid_ctrl  = '0;
        end
    endgenerate

    pipe_skid_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (main_load),
        .clear    (main_clear),
        .load_data(skid_v ? skid_data : data_i),
        .load_ctrl(skid_v ? skid_ctrl : ctrl_i),
        .valid    (main_v),
        .data     (main_data),
        .ctrl     (main_ctrl)
    );

    assign state       = skid_v ? TWO : (main_v ? ONE : EMPTY);
    assign count_o     = state;
    assign out_valid_o = main_v;
    assign data_o      = main_data;
    assign ctrl_o      = main_v ? main_ctrl : '0;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for the skid build (directed) and the
// single-entry build (random valid/ready).
module tb_pipe_stage_reg;
    localparam int DW = 96;
    localparam int CW = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          iv = 1'b0, fl = 1'b0, ordy = 1'b0;
    logic [DW-1:0] d = '0;
    logic [CW-1:0] c = '0;
    logic          ird, ov;
    logic [DW-1:0] dout;
    logic [CW-1:0] cout;
    logic [1:0]    cnt;

    logic          iv0 = 1'b0, ordy0 = 1'b0;
    logic [DW-1:0] d0 = '0;
    logic [CW-1:0] c0 = '0;
    logic          ird0, ov0;
    logic [DW-1:0] dout0;
    logic [CW-1:0] cout0;
    logic [1:0]    cnt0;

    int total = 0;
    int bad = 0;
    logic [DW+CW-1:0] q[$];
    logic [DW+CW-1:0] q0[$];

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv), .in_ready_o(ird), .data_i(d), .ctrl_i(c),
        .flush_i(fl), .out_valid_o(ov), .out_ready_i(ordy), .data_o(dout), .ctrl_o(cout), .count_o(cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv0), .in_ready_o(ird0), .data_i(d0), .ctrl_i(c0),
        .flush_i(1'b0), .out_valid_o(ov0), .out_ready_i(ordy0), .data_o(dout0), .ctrl_o(cout0), .count_o(cnt0)
    );

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // skid build: compare on emit, then record flush / accept for this edge
    always @(negedge clk) begin
        if (rst_n) begin
            logic [DW+CW-1:0] e;
            chk("cnt", cnt, q.size());
            if (!ov) chk("bubble_ctrl", cout, 0);
            if (ov && ordy) begin
                if (q.size() == 0) chk("spurious_emit", dout, 0 - 1);
                else begin
                    e = q.pop_front();
                    chk("data", dout, e[DW-1:0]);
                    chk("ctrl", cout, e[DW+CW-1:DW]);
                end
            end
            if (fl) q.delete();
            else if (iv && ird) q.push_back({c, d});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [DW+CW-1:0] e;
            chk("cnt0", cnt0, q0.size());
            chk("rdy0", ird0, !ov0 | ordy0);
            if (!ov0) chk("bubble_ctrl0", cout0, 0);
            if (ov0 && ordy0) begin
                if (q0.size() == 0) chk("spurious_emit0", dout0, 0 - 1);
                else begin
                    e = q0.pop_front();
                    chk("data0", dout0, e[DW-1:0]);
                    chk("ctrl0", cout0, e[DW+CW-1:DW]);
                end
            end
            if (iv0 && ird0) q0.push_back({c0, d0});
        end
    end

    initial begin
        iv = 1'b1; d = 96'hAB; c = 9'h1FF; ordy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", ov, 0);
        chk("rst_ctrl", cout, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_ready", ird, 1);
        chk("rst_ready0", ird0, 1);
        rst_n = 1'b1;
        tick();
        chk("rst_lat_valid", ov, 1);
        chk("rst_lat_data", dout, 96'hAB);
        iv = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            iv = 1'b1; d = DW'(i); c = 9'h1FF;
            tick();
            chk("stream_valid", ov, 1);
            chk("stream_data", dout, i);
            chk("stream_cnt", cnt, 1);
        end
        iv = 1'b0;
        tick();
        chk("idle_valid", ov, 0);
        chk("idle_ctrl", cout, 0);
        ordy = 1'b0; iv = 1'b1; d = 96'h11; c = 9'h0A5;
        tick();
        chk("bp_cnt1", cnt, 1);
        chk("bp_rdy1", ird, 1);
        d = 96'h22; c = 9'h15A;
        tick();
        chk("bp_cnt2", cnt, 2);
        chk("bp_rdy2", ird, 0);
        chk("bp_data", dout, 96'h11);
        iv = 1'b0;
        repeat (2) tick();
        chk("bp_hold_data", dout, 96'h11);
        chk("bp_hold_ctrl", cout, 9'h0A5);
        chk("bp_hold_cnt", cnt, 2);
        ordy = 1'b1;
        tick();
        chk("bp_drain_data", dout, 96'h22);
        chk("bp_drain_cnt", cnt, 1);
        tick();
        chk("bp_empty_cnt", cnt, 0);
        ordy = 1'b0; iv = 1'b1; d = 96'h44;
        tick();
        d = 96'h55;
        tick();
        chk("fl_pre_cnt", cnt, 2);
        d = 96'h33; fl = 1'b1;
        tick();
        fl = 1'b0; iv = 1'b0;
        chk("fl_valid", ov, 0);
        chk("fl_ctrl", cout, 0);
        chk("fl_cnt", cnt, 0);
        chk("fl_rdy", ird, 1);
        iv = 1'b1; d = 96'h66;
        tick();
        d = 96'h77; fl = 1'b1;
        chk("fl1_rdy", ird, 1);
        tick();
        fl = 1'b0; iv = 1'b0;
        chk("fl1_valid", ov, 0);
        chk("fl1_cnt", cnt, 0);
        ordy = 1'b1;
        repeat (4) tick();
        chk("fl_no_emit", ov, 0);
        for (int i = 0; i < 1000; i++) begin
            iv0 = 1'($urandom_range(0, 1));
            ordy0 = 1'($urandom_range(0, 1));
            d0 = {$urandom(), $urandom(), $urandom()};
            c0 = CW'($urandom());
            tick();
        end
        iv0 = 1'b0; ordy0 = 1'b1;
        repeat (3) tick();
        chk("drain_q", q.size(), 0);
        chk("drain_q0", q0.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
